uart_tx_arbiter: RTL and testbench



---
 rtl/uart_tx_arbiter.sv | 132 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Frame-granular round-robin arbiter sharing one UART TX FIFO write port among NUM_REQ sources.
// Define UART_ARB_HDR_EN to prefix each frame with a header byte (HDR_BASE | grant_idx).
module uart_tx_arbiter #(
    parameter int unsigned          NUM_REQ   = 4,
    parameter int unsigned          DATA_BITS = 8,
    parameter logic [DATA_BITS-1:0] HDR_BASE  = 8'h80,
    localparam int unsigned         IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic                           fifo_full,
    output logic                           fifo_wr_en,
    output logic [DATA_BITS-1:0]           fifo_din,
    output logic                           grant_valid,
    output logic [IDX_W-1:0]               grant_idx,
    output logic                           frame_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1
`ifdef UART_ARB_HDR_EN
        ,
        HDR  = 2'd2
`endif
    } state_t;

    state_t                 state;
    logic [IDX_W-1:0]       last_grant;
    logic [IDX_W-1:0]       pick;
    logic                   found;
    logic [DATA_BITS-1:0]   sel_data;
    logic                   sel_valid;
    logic                   sel_last;

    assign sel_valid = req_valid[grant_idx];
    assign sel_last  = req_last[grant_idx];

    // Round-robin: first scan indices above last_grant, then wrap from 0.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && req_valid[i] && (IDX_W'(i) > last_grant)) begin
                pick  = IDX_W'(i);
                found = 1'b1;
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && req_valid[i]) begin
                pick  = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == IDX_W'(i)) begin
                sel_data = req_data[i*DATA_BITS +: DATA_BITS];
            end
        end
    end

    always_comb begin
        req_ready  = '0;
        fifo_wr_en = 1'b0;
        fifo_din   = '0;
        case (state)
            XFER: begin
                req_ready[grant_idx] = !fifo_full;
                fifo_wr_en           = sel_valid && !fifo_full;
                fifo_din             = sel_data;
            end
`ifdef UART_ARB_HDR_EN
            HDR: begin
                fifo_wr_en = !fifo_full;
                fifo_din   = HDR_BASE | DATA_BITS'(grant_idx);
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
            grant_idx   <= '0;
            frame_done  <= 1'b0;
            last_grant  <= IDX_W'(NUM_REQ - 1);
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        grant_idx   <= pick;
                        grant_valid <= 1'b1;
`ifdef UART_ARB_HDR_EN
                        state       <= HDR;
`else
                        state       <= XFER;
`endif
                    end
                end
`ifdef UART_ARB_HDR_EN
                HDR: begin
                    if (!fifo_full) begin
                        state <= XFER;
                    end
                end
`endif
                XFER: begin
                    // grant_idx is kept so the last owner stays visible after the frame.
                    if (fifo_wr_en && sel_last) begin
                        state       <= IDLE;
                        grant_valid <= 1'b0;
                        frame_done  <= 1'b1;
                        last_grant  <= grant_idx;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: per-requester source queues, a write scoreboard,
// and a vector table for the FIFO-full stall frame.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_last;
    logic [N-1:0]      req_ready;
    logic              fifo_full;
    logic              fifo_wr_en;
    logic [DW-1:0]     fifo_din;
    logic              grant_valid;
    logic [IW-1:0]     grant_idx;
    logic              frame_done;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ   (N),
        .DATA_BITS (DW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .fifo_full   (fifo_full),
        .fifo_wr_en  (fifo_wr_en),
        .fifo_din    (fifo_din),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .frame_done  (frame_done)
    );

    typedef struct {
        logic [7:0] data;
        logic       last;
    } src_t;

    typedef struct {
        logic [7:0]    data;
        logic [IW-1:0] idx;
        logic          last;
    } exp_t;

    typedef struct {
        logic       full;
        logic [3:0] rdy;
        logic       wr;
        logic       gv;
    } vec_t;

    src_t         src_q[N][$];
    exp_t         sb[$];
    vec_t         vecs[$];
    exp_t         mon_e;
    logic [N-1:0] hold     = '0;
    logic [N-1:0] acc_snap = '0;
    int           n_cmp    = 0;
    int           n_bad    = 0;
    int           wcount   = 0;
    int           cyc      = 0;
    int           prev_wcyc = -1;
    bit           prev_last = 1'b0;
    bit           chk_gap  = 1'b0;
    bit           mon_en   = 1'b0;
    logic         fd_pend  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Requester models: present the head of each source queue, pop it once accepted.
    initial begin
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (acc_snap[i] && src_q[i].size() > 0) src_q[i].delete(0);
                if (src_q[i].size() > 0) begin
                    req_valid[i]          = !hold[i];
                    req_data[i*DW +: DW]  = src_q[i][0].data;
                    req_last[i]           = src_q[i][0].last;
                end else begin
                    req_valid[i]          = 1'b0;
                    req_data[i*DW +: DW]  = '0;
                    req_last[i]           = 1'b0;
                end
            end
        end
    end

    // Write monitor and scoreboard consumer.
    always @(negedge clk) begin
        cyc++;
        acc_snap = rst ? '0 : (req_valid & req_ready);
        if (mon_en) begin
            chk("frame_done", {31'b0, frame_done}, {31'b0, fd_pend});
            fd_pend = 1'b0;
            if (fifo_wr_en) begin
                wcount++;
                if (sb.size() == 0) begin
                    chk("write_with_empty_scoreboard", sb.size(), 1);
                end else begin
                    mon_e = sb.pop_front();
                    chk("wr_data", {24'b0, fifo_din}, {24'b0, mon_e.data});
                    chk("wr_grant_idx", {30'b0, grant_idx}, {30'b0, mon_e.idx});
                    if (chk_gap && prev_wcyc >= 0)
                        chk("wr_gap", cyc - prev_wcyc, prev_last ? 2 : 1);
                    prev_wcyc = cyc;
                    prev_last = mon_e.last;
                    fd_pend   = mon_e.last && !rst;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, compared=%0d mismatched=%0d", n_cmp, n_bad);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input int r, input logic [7:0] first, input logic [7:0] step, input int n);
        logic [7:0] d;
        src_t       s;
        exp_t       e;
        d = first;
`ifdef UART_ARB_HDR_EN
        e.data = 8'h80 | 8'(r);
        e.idx  = IW'(r);
        e.last = 1'b0;
        sb.push_back(e);
`endif
        for (int k = 0; k < n; k++) begin
            s.data = d;
            s.last = (k == n - 1);
            src_q[r].push_back(s);
            e.data = d;
            e.idx  = IW'(r);
            e.last = s.last;
            sb.push_back(e);
            d = d + step;
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        fifo_full = 1'b0;
        hold      = '0;
        for (int i = 0; i < N; i++) src_q[i].delete();
        sb.delete();
        tick();
        tick();
        rst       = 1'b0;
        prev_wcyc = -1;
        chk_gap   = 1'b0;
    endtask

    task automatic check_reset(input string name);
        chk({name, "_grant_valid"}, {31'b0, grant_valid}, 0);
        chk({name, "_grant_idx"}, {30'b0, grant_idx}, 0);
        chk({name, "_frame_done"}, {31'b0, frame_done}, 0);
        chk({name, "_req_ready"}, {28'b0, req_ready}, 0);
        chk({name, "_fifo_wr_en"}, {31'b0, fifo_wr_en}, 0);
        chk({name, "_fifo_din"}, {24'b0, fifo_din}, 0);
    endtask

    task automatic wait_idle(input string name, input int limit);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (sb.size() == 0 && !grant_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk({name, "_drained"}, {31'b0, ok}, 1);
    endtask

    initial begin
        int  w0;
        int  need;
        bit  ok;
        vec_t v;

`ifdef UART_ARB_HDR_EN
        v = '{full: 1'b0, rdy: 4'b0000, wr: 1'b1, gv: 1'b1}; vecs.push_back(v);
`endif
        v = '{full: 1'b0, rdy: 4'b0010, wr: 1'b1, gv: 1'b1}; vecs.push_back(v);
        v = '{full: 1'b0, rdy: 4'b0010, wr: 1'b1, gv: 1'b1}; vecs.push_back(v);
        for (int i = 0; i < 5; i++) begin
            v = '{full: 1'b1, rdy: 4'b0000, wr: 1'b0, gv: 1'b1}; vecs.push_back(v);
        end
        v = '{full: 1'b0, rdy: 4'b0010, wr: 1'b1, gv: 1'b1}; vecs.push_back(v);
        v = '{full: 1'b0, rdy: 4'b0010, wr: 1'b1, gv: 1'b1}; vecs.push_back(v);
        v = '{full: 1'b0, rdy: 4'b0000, wr: 1'b0, gv: 1'b0}; vecs.push_back(v);

        rst       = 1'b1;
        fifo_full = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check_reset("init");
        mon_en = 1'b1;
        tick();

        // Requester 2, three consecutive bytes.
        do_reset();
        chk_gap = 1'b1;
        send(2, 8'h11, 8'h11, 3);
        wait_idle("s1", 30);
        chk("s1_grant_idx_held", {30'b0, grant_idx}, 2);

        // Four requesters, two rounds of single-byte frames.
        do_reset();
        chk_gap = 1'b1;
        for (int rnd = 0; rnd < 2; rnd++)
            for (int r = 0; r < N; r++)
                send(r, 8'hAA + 8'(8'h11 * r), 8'h00, 1);
        wait_idle("s2", 60);
        chk_gap = 1'b0;

        // Requester 1, four bytes with a five-cycle FIFO-full stall, vector table.
        do_reset();
        send(1, 8'h41, 8'h01, 4);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (grant_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk("s3_grant_seen", {31'b0, ok}, 1);
        foreach (vecs[k]) begin
            fifo_full = vecs[k].full;
            @(negedge clk);
            chk($sformatf("s3_v%0d_req_ready", k), {28'b0, req_ready}, {28'b0, vecs[k].rdy});
            chk($sformatf("s3_v%0d_fifo_wr_en", k), {31'b0, fifo_wr_en}, {31'b0, vecs[k].wr});
            chk($sformatf("s3_v%0d_grant_valid", k), {31'b0, grant_valid}, {31'b0, vecs[k].gv});
            tick();
        end
        fifo_full = 1'b0;
        wait_idle("s3", 20);

        // Requester 0 drops valid mid-frame while requester 3 waits.
        do_reset();
        send(0, 8'h01, 8'h01, 3);
        send(3, 8'h31, 8'h01, 2);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (src_q[0].size() == 2) begin
                ok = 1'b1;
                break;
            end
        end
        chk("s4_first_byte_taken", {31'b0, ok}, 1);
        hold[0] = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("s4_grant_idx", {30'b0, grant_idx}, 0);
            chk("s4_grant_valid", {31'b0, grant_valid}, 1);
            chk("s4_fifo_wr_en", {31'b0, fifo_wr_en}, 0);
            chk("s4_req_ready3", {31'b0, req_ready[3]}, 0);
            tick();
        end
        hold[0] = 1'b0;
        wait_idle("s4", 30);

        // Reset after the second of four bytes; arbitration restarts from requester 0.
        do_reset();
        send(0, 8'h5A, 8'h00, 1);
        wait_idle("s5a", 20);
        send(1, 8'h61, 8'h01, 4);
        w0 = wcount;
`ifdef UART_ARB_HDR_EN
        need = 3;
`else
        need = 2;
`endif
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (wcount >= w0 + need) begin
                ok = 1'b1;
                break;
            end
        end
        chk("s5_two_bytes_written", {31'b0, ok}, 1);
        rst       = 1'b1;
        fifo_full = 1'b1;
        src_q[1].delete();
        sb.delete();
        tick();
        fifo_full = 1'b0;
        @(negedge clk);
        check_reset("s5_mid");
        tick();
        rst       = 1'b0;
        prev_wcyc = -1;
        send(0, 8'h70, 8'h00, 1);
        send(1, 8'h71, 8'h00, 1);
        wait_idle("s5b", 30);

        // last_grant = 1 with requesters 1 and 3 pending: 3 first, then 1.
        do_reset();
        send(1, 8'h51, 8'h00, 1);
        wait_idle("s6a", 20);
        send(3, 8'h53, 8'h00, 1);
        send(1, 8'h52, 8'h00, 1);
        wait_idle("s6b", 30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
